// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared state, opcode, unit, trap-cause codes and watchdog limit for instr_dispatch
package dispatch_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_TRAP} state_t;
    localparam logic [3:0] OP_ALUI = 4'h8;
    localparam logic [3:0] OP_MLS  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_MOVI = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam int NUNITS = 5;
    typedef logic [2:0] unit_t;
    localparam unit_t U_ALU  = 3'd0;
    localparam unit_t U_ALUI = 3'd1;
    localparam unit_t U_MLS  = 3'd2;
    localparam unit_t U_MOV  = 3'd3;
    localparam unit_t U_MOVI = 3'd4;
    typedef enum logic [1:0] {TC_NONE = 2'b00, TC_ILLEGAL = 2'b01, TC_WDT = 2'b10, TC_STRAY = 2'b11} cause_t;
    localparam logic [7:0] WDT_LIMIT = 8'd255;
    function automatic logic [NUNITS-1:0] unit_onehot(input unit_t u);
        return {{(NUNITS-1){1'b0}}, 1'b1} << u;
    endfunction
endpackage

// File: rtl/dispatch_decode.sv
// dispatch_decode: maps an instruction word to its execution unit plus HALT and illegal flags
//   ir_i      : instruction word (only the opcode nibble matters)
//   unit_o    : unit index for legal unit classes
//   halt_o    : opcode is HALT
//   illegal_o : opcode is neither a unit class nor HALT
module dispatch_decode
    import dispatch_pkg::*;
(
    input  logic [15:0] ir_i,
    output unit_t       unit_o,
    output logic        halt_o,
    output logic        illegal_o
);
    logic [3:0] op;
    logic       unused_bits;
    assign op          = ir_i[15:12];
    assign unused_bits = ^ir_i[11:0];
    assign unit_o      = !op[3] ? U_ALU : op == OP_ALUI ? U_ALUI : op == OP_MLS ? U_MLS :
                         op == OP_MOV ? U_MOV : U_MOVI;
    assign halt_o      = op == OP_HALT;
    // 1100..1110 are the only unassigned opcodes
    assign illegal_o   = op[3] && op[2] && !halt_o;
endmodule

// File: rtl/instr_dispatch.sv
// instr_dispatch: fetch/decode/execute sequencer launching one of five execution units
//   clk, rst          : clock, asynchronous active-high reset
//   run               : permits fetching new instructions
//   ir                : instruction word, stable from fetch_done to next fetch_start
//   fetch_done        : fetch completion pulse
//   exec_done[4:0]    : unit completion pulses (ALU, ALUI, MLS, MOV, MOVI)
//   fetch_start       : one-cycle fetch launch
//   exec_start[4:0]   : one-hot one-cycle unit launch
//   busy, trap        : not idle / trapped
//   trap_cause[1:0]   : 00 none, 01 illegal, 10 watchdog, 11 stray done
//   instr_count[15:0] : retired instructions, wrapping
// Define DISPATCH_WDT_EN to add the FETCH/EXEC watchdog.
module instr_dispatch
    import dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic        fetch_done,
    input  logic [4:0]  exec_done,
    output logic        fetch_start,
    output logic [4:0]  exec_start,
    output logic        busy,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [15:0] instr_count
);
    state_t      state_q, state_d;
    unit_t       unit_q, unit_d, dec_unit;
    cause_t      cause_q, cause_d;
    logic [4:0]  exec_start_q, exec_start_d;
    logic [15:0] count_q, count_d;
    logic        fetch_start_q, fetch_start_d, busy_q, trap_q;
    logic        dec_halt, dec_illegal, unit_done, stray, wdt_expired;

    dispatch_decode u_decode (.ir_i(ir), .unit_o(dec_unit), .halt_o(dec_halt), .illegal_o(dec_illegal));

    assign unit_done = |(exec_done & unit_onehot(unit_q));
    // outside EXEC every done is stray; inside it only the latched unit may report
    assign stray     = state_q == ST_EXEC ? |(exec_done & ~unit_onehot(unit_q)) : |exec_done;

`ifdef DISPATCH_WDT_EN
    logic [7:0] wdt_q, wdt_d;
    // fires on the waiting cycle that brings the count to WDT_LIMIT
    assign wdt_expired = wdt_q == WDT_LIMIT - 8'd1;
    assign wdt_d = state_d != state_q ? 8'd0 :
                   (state_q == ST_FETCH || state_q == ST_EXEC) ? wdt_q + 8'd1 : wdt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wdt_q <= 8'd0;
        else     wdt_q <= wdt_d;
    end
`else
    assign wdt_expired = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        unit_d        = unit_q;
        cause_d       = cause_q;
        count_d       = count_q;
        fetch_start_d = 1'b0;
        exec_start_d  = 5'b0;
        if (stray && state_q != ST_TRAP) begin
            state_d = ST_TRAP;
            cause_d = TC_STRAY;
        end else case (state_q)
            ST_IDLE: if (run) begin
                state_d       = ST_FETCH;
                fetch_start_d = 1'b1;
            end
            ST_FETCH: if (fetch_done) state_d = ST_DECODE;
                else if (wdt_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TC_WDT;
                end
            ST_DECODE: if (dec_illegal) begin
                    state_d = ST_TRAP;
                    cause_d = TC_ILLEGAL;
                end else if (dec_halt) begin
                    state_d = ST_IDLE;
                    count_d = count_q + 16'd1;
                end else begin
                    state_d      = ST_EXEC;
                    unit_d       = dec_unit;
                    exec_start_d = unit_onehot(dec_unit);
                end
            ST_EXEC: if (unit_done) begin
                    state_d       = run ? ST_FETCH : ST_IDLE;
                    fetch_start_d = run;
                    count_d       = count_q + 16'd1;
                end else if (wdt_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TC_WDT;
                end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            unit_q        <= U_ALU;
            cause_q       <= TC_NONE;
            count_q       <= 16'd0;
            fetch_start_q <= 1'b0;
            exec_start_q  <= 5'b0;
            busy_q        <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            unit_q        <= unit_d;
            cause_q       <= cause_d;
            count_q       <= count_d;
            fetch_start_q <= fetch_start_d;
            exec_start_q  <= exec_start_d;
            busy_q        <= state_d != ST_IDLE;
            trap_q        <= state_d == ST_TRAP;
        end
    end

    assign fetch_start = fetch_start_q;
    assign exec_start  = exec_start_q;
    assign busy        = busy_q;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;
    assign instr_count = count_q;
endmodule
